// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared result-select and load-type encodings for the WB stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  typedef logic [1:0] res_src_t;

  localparam res_src_t RES_ALU  = 2'b00;
  localparam res_src_t RES_LOAD = 2'b01;
  localparam res_src_t RES_PC4  = 2'b10;
  localparam res_src_t RES_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Byte/halfword/word extraction from an aligned word with sign/zero extension.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = raw[7:0];
    case (offset)
      2'd0: w_byte = raw[7:0];
      2'd1: w_byte = raw[15:8];
      2'd2: w_byte = raw[23:16];
      2'd3: w_byte = raw[31:24];
      default: w_byte = raw[7:0];
    endcase
    // Halfword misalignment is trapped upstream, so offset[0] is ignored.
    w_half = offset[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    ext_data = raw;
    case (funct3)
      F3_LB:   ext_data = XLEN'($signed(w_byte));
      F3_LBU:  ext_data = XLEN'(w_byte);
      F3_LH:   ext_data = XLEN'($signed(w_half));
      F3_LHU:  ext_data = XLEN'(w_half);
      F3_LW:   ext_data = XLEN'($signed(raw[31:0]));
      default: ext_data = raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage_pipe.sv
// ============================================================================
// Module : writeback_stage_pipe
// Brief  : MEM/WB pipeline register, load extension and 4-way result select.
//          Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [REG_ADDR_W-1:0] RDM,
  input  logic [XLEN-1:0]       ALU_ResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       ImmExtM,
  input  logic                  StallW,
  input  logic                  FlushW,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]           RetireCntW,
`endif
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RDW,
  output logic [XLEN-1:0]       ResultW
);

  logic                  r_valid;
  logic                  r_regwrite;
  res_src_t              r_src;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_alu;
  logic [XLEN-1:0]       r_rdata;
  logic [XLEN-1:0]       r_pc4;
  logic [XLEN-1:0]       r_imm;
  logic [XLEN-1:0]       w_load;

  // Flush only kills valid/regwrite; the data fields keep their old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_src      <= RES_ALU;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_imm      <= '0;
    end else if (FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!StallW) begin
      r_valid    <= ValidM;
      r_regwrite <= RegWriteM;
      r_src      <= ResultSrcM;
      r_funct3   <= Funct3M;
      r_rd       <= RDM;
      r_alu      <= ALU_ResultM;
      r_rdata    <= ReadDataM;
      r_pc4      <= PCPlus4M;
      r_imm      <= ImmExtM;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (!FlushW && !StallW && ValidM) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign RetireCntW = r_retire_cnt;
`endif

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .funct3   (r_funct3),
    .offset   (r_alu[1:0]),
    .raw      (r_rdata),
    .ext_data (w_load)
  );

  always_comb begin
    ResultW = r_alu;
    case (r_src)
      RES_ALU:  ResultW = r_alu;
      RES_LOAD: ResultW = w_load;
      RES_PC4:  ResultW = r_pc4;
      RES_IMM:  ResultW = r_imm;
      default:  ResultW = r_alu;
    endcase
  end

  assign ValidW    = r_valid;
  assign RegWriteW = r_valid & r_regwrite & (r_rd != '0);
  assign RDW       = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage_pipe.sv
// ============================================================================
// Module : tb_writeback_stage_pipe
// Brief  : Scoreboard bench for writeback_stage_pipe against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, StallW, FlushW;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RDM;
  logic [31:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;
  logic        ValidW, RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] RetireCntW;
`endif

  always #5 clk = ~clk;

  writeback_stage_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidM      (ValidM),
    .RegWriteM   (RegWriteM),
    .ResultSrcM  (ResultSrcM),
    .Funct3M     (Funct3M),
    .RDM         (RDM),
    .ALU_ResultM (ALU_ResultM),
    .ReadDataM   (ReadDataM),
    .PCPlus4M    (PCPlus4M),
    .ImmExtM     (ImmExtM),
    .StallW      (StallW),
    .FlushW      (FlushW),
`ifdef WB_RETIRE_CNT_EN
    .RetireCntW  (RetireCntW),
`endif
    .ValidW      (ValidW),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW)
  );

  typedef struct {
    bit          valid;
    bit          regwrite;
    bit [4:0]    rd;
    bit [31:0]   result;
    bit [63:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model of the instruction held in WB.
  bit        m_valid, m_rw;
  bit [1:0]  m_src;
  bit [2:0]  m_f3;
  bit [4:0]  m_rd;
  bit [31:0] m_alu, m_rdata, m_pc4, m_imm;
  bit [63:0] m_cnt;

  function automatic bit [31:0] ref_load(bit [2:0] f3, int off, bit [31:0] word);
    bit [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (off >= 2) ? (word >> 16) : (word & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic bit [31:0] ref_result();
    case (m_src)
      2'd0:    return m_alu;
      2'd1:    return ref_load(m_f3, int'(m_alu % 4), m_rdata);
      2'd2:    return m_pc4;
      default: return m_imm;
    endcase
  endfunction

  task automatic apply(input bit r, input bit v, input bit rw, input bit [1:0] src,
                       input bit [2:0] f3, input bit [4:0] rd, input bit [31:0] alu,
                       input bit [31:0] rdata, input bit [31:0] pc4, input bit [31:0] imm,
                       input bit st, input bit fl);
    exp_t e;
    @(negedge clk);
    rst = r; ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3; RDM = rd;
    ALU_ResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    StallW = st; FlushW = fl;
    if (!r) begin
      m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_rw = 0;
    end else if (!st) begin
      m_valid = v; m_rw = rw; m_src = src; m_f3 = f3; m_rd = rd;
      m_alu = alu; m_rdata = rdata; m_pc4 = pc4; m_imm = imm;
      if (v) m_cnt = m_cnt + 1;
    end
    e.valid    = m_valid;
    e.regwrite = m_valid && m_rw && (m_rd != 0);
    e.rd       = m_rd;
    e.result   = ref_result();
    e.cnt      = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: W outputs are stable one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ValidW", 64'(ValidW), 64'(e.valid));
        chk("RegWriteW", 64'(RegWriteW), 64'(e.regwrite));
        chk("RDW", 64'(RDW), 64'(e.rd));
        chk("ResultW", 64'(ResultW), 64'(e.result));
`ifdef WB_RETIRE_CNT_EN
        chk("RetireCntW", RetireCntW, e.cnt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0; ValidM = 0; RegWriteM = 0; ResultSrcM = 0; Funct3M = 0; RDM = 0;
    ALU_ResultM = 0; ReadDataM = 0; PCPlus4M = 0; ImmExtM = 0; StallW = 0; FlushW = 0;

    // Reset held with random M inputs.
    repeat (3) apply(0, 1, 1, 2'($urandom), 3'($urandom), 5'($urandom), $urandom,
                     $urandom, $urandom, $urandom, 0, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0, 0);

    // Load extraction.
    apply(1, 1, 1, 2'd1, 3'd0, 5'd6, 32'h2, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd4, 5'd6, 32'h2, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd1, 5'd7, 32'h2, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd5, 5'd7, 32'h2, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd0, 5'd8, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd1, 5'd8, 32'h3, 32'h80FF_7F01, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd1, 3'd2, 5'd8, 32'h1, 32'h80FF_7F01, 0, 0, 0, 0);

    // Source select and x0 suppression.
    apply(1, 1, 1, 2'd2, 3'd0, 5'd9, 32'h55, 0, 32'h104, 0, 0, 0);
    apply(1, 1, 1, 2'd3, 3'd0, 5'd9, 32'h55, 0, 0, 32'hABCD_E000, 0, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd0, 32'h77, 0, 0, 0, 0, 0);

    // Stall holds A while M changes; stall+flush gives a bubble.
    apply(1, 1, 1, 2'd0, 3'd0, 5'd10, 32'hAAAA_0001, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd3, 3'd0, 5'd11, 32'h1, 0, 0, 32'hDEAD, 1, 0);
    apply(1, 0, 0, 2'd2, 3'd0, 5'd12, 32'h2, 0, 32'hBEEF, 0, 1, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd13, 32'h3, 0, 0, 0, 1, 1);
    // Reset asserted during a stall.
    apply(0, 1, 1, 2'd0, 3'd0, 5'd14, 32'h4, 0, 0, 0, 1, 0);

    // Retire count: 3 valid captures, 1 stalled, 1 flushed, 1 invalid.
    apply(1, 1, 1, 2'd0, 3'd0, 5'd1, 32'h10, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd2, 32'h20, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 2'd0, 3'd0, 5'd3, 32'h30, 0, 0, 0, 1, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd4, 32'h40, 0, 0, 0, 0, 1);
    apply(1, 0, 1, 2'd0, 3'd0, 5'd5, 32'h50, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 2'd0, 3'd0, 5'd6, 32'h60, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
            3'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_stage_pipe.md
Name: writeback_stage_pipe

Overview:
Parametrised successor to the single-mux write-back stage. Holds the MEM/WB pipeline register and selects among four result sources. Performs load-data byte/halfword extraction with sign/zero extension, and drives the register-file write port. Sits between the memory stage and the register file / forwarding unit, with stall and flush control from the hazard unit.

Parameters:
XLEN, 32, datapath width in bits; must be 32 or 64.
REG_ADDR_W, 5, register-file address width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ValidM  in  1  memory-stage instruction valid
RegWriteM  in  1  instruction writes a register
ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
Funct3M  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
RDM  in  REG_ADDR_W  destination register
ALU_ResultM  in  XLEN  ALU result / load address
ReadDataM  in  XLEN  raw aligned word from data memory
PCPlus4M  in  XLEN  return address
ImmExtM  in  XLEN  extended immediate (LUI)
StallW  in  1  hold WB register
FlushW  in  1  insert bubble into WB register
ValidW  out  1  WB instruction valid
RegWriteW  out  1  register-file write enable (qualified)
RDW  out  REG_ADDR_W  register-file write address
ResultW  out  XLEN  write-back data, also the forwarding source

Behaviour:
- Reset (rst low, async): all pipeline fields are cleared. ValidW=0, RegWriteW=0, RDW=0, ResultW=0 (ResultSrc=00, ALU field=0).
- Rising edge, rst high, in priority order:
  - FlushW=1: load a bubble (valid=0, regwrite=0, other fields don't-care but held stable). Flush beats stall.
  - StallW=1: hold all fields.
  - Otherwise: capture all *M inputs.
- Latency: 1 cycle from M inputs to W outputs. ResultW is combinational from the registered fields.
- RegWriteW = valid_q & regwrite_q & (rd_q != 0). A write to x0 is never issued.
- Result select:
  - 00: ALU_Result.
  - 01: load-extended data.
  - 10: PCPlus4.
  - 11: ImmExt.
- Load extraction uses offset = ALU_Result[1:0].
  - LB/LBU: byte = ReadData[8*offset+7 : 8*offset]; LB sign-extends to XLEN, LBU zero-extends.
  - LH/LHU: half = offset[1] ? ReadData[31:16] : ReadData[15:0]. offset[0] is ignored; misalignment is trapped upstream. LH sign-extends, LHU zero-extends.
  - LW: ReadData[31:0]. Sign-extended when XLEN=64, pass-through when XLEN=32.
  - Any other Funct3: full ReadData unchanged.
- When valid_q=0, ResultW still reflects the held fields. Consumers qualify on ValidW / RegWriteW.
- Simultaneous StallW and FlushW: treated as flush.
- Reset asserted mid-stall: reset wins immediately (asynchronous).

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: adds output RetireCntW [63:0]. The counter is cleared by reset and increments by 1 on each edge where the stage captures with ValidM=1 (not stalled, not flushed). It wraps at 2^64-1 to 0.
- Undefined: the port and the counter are absent; no other behaviour changes.

Decomposition:
- Package wb_pkg:
  - result-source constants RES_ALU/RES_LOAD/RES_PC4/RES_IMM;
  - funct3 load constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU;
  - a typedef for the 2-bit result-select field.
- Sub-module load_extend: combinational, with inputs funct3, offset, raw word and output XLEN-wide extended data. Instantiated once.

Test Plan:
- Reset: hold rst=0, drive random M inputs -> ValidW=0, RegWriteW=0, ResultW=0. Release, capture ALU_ResultM=0x0000_1234, ResultSrcM=00, RDM=5, RegWriteM=1, ValidM=1 -> next cycle ResultW=0x1234, RDW=5, RegWriteW=1.
- Load extraction:
  - ReadDataM=0x80FF_7F01, ResultSrcM=01, ALU_Result[1:0]=2, LB -> ResultW=0xFFFF_FFFF; LBU -> 0x0000_00FF.
  - offset=2 with LH -> 0xFFFF_80FF; with LHU -> 0x0000_80FF.
  - offset=0 with LB -> 0x0000_0001.
- Source select: ResultSrcM=10, PCPlus4M=0x104 -> ResultW=0x104. ResultSrcM=11, ImmExtM=0xABCD_E000 -> ResultW=0xABCD_E000.
- x0 suppression: RDM=0, RegWriteM=1, ValidM=1 -> RegWriteW=0.
- Hazards:
  - Capture instr A, then StallW=1 for 2 cycles while M changes -> W outputs stay A.
  - StallW=1 with FlushW=1 -> ValidW=0, RegWriteW=0 next cycle.
- WB_RETIRE_CNT_EN defined: 3 valid captures, 1 stalled, 1 flushed, 1 with ValidM=0 -> RetireCntW=3.
